// File: rtl/axi4lite_slave_mem.sv
// -----------------------------------------------------------------------------
// axi4lite_slave_mem
//
// AXI4-lite responder backed by a word-addressed memory of MEMDEPTH words of
// DATAWIDTH bits. Separate write and read FSMs run independently; every output
// comes straight from a flop.
//
// Handshake semantics (all five channels): a transfer happens on a rising edge
// where both VALID and READY are sampled high. The sender holds VALID and its
// payload stable until that edge; this block only ever raises READY from
// registered state, so there is no input-to-output combinational path.
//
// Ports:
//   clk, rst_N                       clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY           write address channel
//   WDATA/WSTRB/WVALID/WREADY        write data channel (byte-lane strobes)
//   BRESP/BVALID/BREADY              write response (00 OKAY, 10 SLVERR)
//   ARADDR/ARVALID/ARREADY           read address channel
//   RDATA/RRESP/RVALID/RREADY        read data channel (00 OKAY, 10 SLVERR)
//   dbg_wr_state_o, dbg_rd_state_o   current write / read FSM state
// -----------------------------------------------------------------------------
module axi4lite_slave_mem #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int MEMDEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_N,
  // write address
  input  logic [ADDRWIDTH-1:0]   AWADDR,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  // write data
  input  logic [DATAWIDTH-1:0]   WDATA,
  input  logic [DATAWIDTH/8-1:0] WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  // write response
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  // read address
  input  logic [ADDRWIDTH-1:0]   ARADDR,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  // read data
  output logic [DATAWIDTH-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  // FSM state observation
  output logic [1:0]             dbg_wr_state_o,
  output logic                   dbg_rd_state_o
);

  localparam int STRBW = DATAWIDTH / 8;
  localparam int OFFW  = $clog2(STRBW);
  localparam int IDXW  = $clog2(MEMDEPTH);
  // One extra bit so the byte-size constant cannot overflow ADDRWIDTH.
  localparam logic [ADDRWIDTH:0] MEM_BYTES = (ADDRWIDTH + 1)'(MEMDEPTH * STRBW);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  function automatic logic addr_in_range(input logic [ADDRWIDTH-1:0] a);
    return {1'b0, a} < MEM_BYTES;
  endfunction

  // Byte-offset bits are dropped; out-of-range addresses are filtered
  // separately, so aliasing here is harmless.
  function automatic logic [IDXW-1:0] word_idx(input logic [ADDRWIDTH-1:0] a);
    return a[OFFW +: IDXW];
  endfunction

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  w_state_e               w_state_q, w_state_d;
  logic                   awready_q, awready_d;
  logic                   wready_q,  wready_d;
  logic [ADDRWIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic                   aw_got_q,  aw_got_d;
  logic [DATAWIDTH-1:0]   w_data_q,  w_data_d;
  logic [STRBW-1:0]       w_strb_q,  w_strb_d;
  logic                   w_got_q,   w_got_d;
  logic                   bvalid_q,  bvalid_d;
  logic [1:0]             bresp_q,   bresp_d;
  logic                   mem_we;

  logic [DATAWIDTH-1:0]   mem_q [MEMDEPTH];

  logic aw_hs;
  logic w_hs;

  assign aw_hs = AWVALID && awready_q;
  assign w_hs  = WVALID  && wready_q;

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_addr_d = aw_addr_q;
    aw_got_d  = aw_got_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_got_d   = w_got_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_addr_d = AWADDR;
          aw_got_d  = 1'b1;
        end
        if (w_hs) begin
          w_data_d = WDATA;
          w_strb_d = WSTRB;
          w_got_d  = 1'b1;
        end
        // Each ready stays up until its own channel has been captured; this
        // also raises both readies on the first edge after reset.
        awready_d = !(aw_got_q || aw_hs);
        wready_d  = !(w_got_q  || w_hs);
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          w_state_d = W_EXEC;
        end
      end

      W_EXEC: begin
        // Commit edge: the memory update and the response are launched together.
        mem_we    = addr_in_range(aw_addr_q);
        bresp_d   = addr_in_range(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
        bvalid_d  = 1'b1;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        w_state_d = W_RESP;
      end

      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end

      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_addr_q <= '0;
      aw_got_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_got_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_addr_q <= aw_addr_d;
      aw_got_q  <= aw_got_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      w_got_q   <= w_got_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array: cleared by reset, byte-lane writes on the commit edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      for (int i = 0; i < MEMDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < STRBW; b++) begin
        if (w_strb_q[b]) begin
          mem_q[word_idx(aw_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e               r_state_q, r_state_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q,  rvalid_d;
  logic [DATAWIDTH-1:0]   rdata_q,   rdata_d;
  logic [1:0]             rresp_q,   rresp_d;

  logic ar_hs;

  assign ar_hs = ARVALID && arready_q;

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          // mem_q is sampled before this edge's write lands, so a read that
          // hits the same edge as a write commit returns the old contents.
          if (addr_in_range(ARADDR)) begin
            rdata_d = mem_q[word_idx(ARADDR)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          r_state_d = R_DATA;
        end
      end

      R_DATA: begin
        // RDATA/RRESP are left alone on completion so they keep their value.
        if (RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end

      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign AWREADY        = awready_q;
  assign WREADY         = wready_q;
  assign BVALID         = bvalid_q;
  assign BRESP          = bresp_q;
  assign ARREADY        = arready_q;
  assign RVALID         = rvalid_q;
  assign RDATA          = rdata_q;
  assign RRESP          = rresp_q;
  assign dbg_wr_state_o = w_state_q;
  assign dbg_rd_state_o = r_state_q;

endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_slave_mem
//
// Directed bench for axi4lite_slave_mem (32-bit address/data, 16 words).
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge, half a cycle away from the active rising edge. A byte-lane memory model
// in the bench produces expected read data; expected responses are queued when
// a request is driven and popped when the DUT answers.
// -----------------------------------------------------------------------------
module tb_axi4lite_slave_mem;

  logic        clk;
  logic        rst_N;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [1:0]  dbg_wr_state;
  logic        dbg_rd_state;

  axi4lite_slave_mem #(
    .ADDRWIDTH(32),
    .DATAWIDTH(32),
    .MEMDEPTH (16)
  ) dut (
    .clk           (clk),
    .rst_N         (rst_N),
    .AWADDR        (AWADDR),
    .AWVALID       (AWVALID),
    .AWREADY       (AWREADY),
    .WDATA         (WDATA),
    .WSTRB         (WSTRB),
    .WVALID        (WVALID),
    .WREADY        (WREADY),
    .BRESP         (BRESP),
    .BVALID        (BVALID),
    .BREADY        (BREADY),
    .ARADDR        (ARADDR),
    .ARVALID       (ARVALID),
    .ARREADY       (ARREADY),
    .RDATA         (RDATA),
    .RRESP         (RRESP),
    .RVALID        (RVALID),
    .RREADY        (RREADY),
    .dbg_wr_state_o(dbg_wr_state),
    .dbg_rd_state_o(dbg_rd_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q   [$];   // expected RDATA
  logic [1:0]  exp_r_q [$];   // expected RRESP
  logic [1:0]  exp_b_q [$];   // expected BRESP
  logic [31:0] model_mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic oor(input logic [31:0] a);
    return a >= 32'd64;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // w_lead: cycles that W is presented ahead of AW (0 = same cycle).
  // bp: extra cycles BREADY is held low once BVALID is seen.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, input int bp);
    logic [1:0] eb;
    int         lat;
    @(negedge clk);
    chk("wr_awready_idle", 32'(AWREADY), 32'd1);
    chk("wr_wready_idle", 32'(WREADY), 32'd1);
    WDATA  = data;
    WSTRB  = strb;
    WVALID = 1'b1;
    BREADY = (bp == 0);
    for (int i = 0; i < w_lead; i++) begin
      @(negedge clk);
      WVALID = 1'b0;
      chk("split_wready_low", 32'(WREADY), 32'd0);
      chk("split_awready_high", 32'(AWREADY), 32'd1);
    end
    AWADDR  = addr;
    AWVALID = 1'b1;
    exp_b_q.push_back(oor(addr) ? 2'b10 : 2'b00);
    if (!oor(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
      end
    end
    @(negedge clk);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    lat = 1;
    while (BVALID !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("wr_bvalid_latency", 32'(lat), 32'd2);
    eb = exp_b_q.pop_front();
    chk("wr_bresp", 32'(BRESP), 32'(eb));
    if (bp > 0) begin
      // Offer a new write while the response is stalled; it must not be taken.
      AWADDR  = 32'h0;
      AWVALID = 1'b1;
      WDATA   = ~data;
      WVALID  = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_bvalid_hold", 32'(BVALID), 32'd1);
        chk("bp_bresp_hold", 32'(BRESP), 32'(eb));
        chk("bp_awready_low", 32'(AWREADY), 32'd0);
        chk("bp_wready_low", 32'(WREADY), 32'd0);
      end
      BREADY  = 1'b1;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end
    @(negedge clk);
    chk("wr_bvalid_drop", 32'(BVALID), 32'd0);
    chk("wr_bresp_clear", 32'(BRESP), 32'd0);
    chk("wr_awready_back", 32'(AWREADY), 32'd1);
    chk("wr_wready_back", 32'(WREADY), 32'd1);
  endtask

  // bp: extra cycles RREADY is held low once RVALID is seen.
  task automatic do_read(input logic [31:0] addr, input int bp);
    logic [31:0] ed;
    logic [1:0]  er;
    int          lat;
    @(negedge clk);
    chk("rd_arready_idle", 32'(ARREADY), 32'd1);
    ARADDR  = addr;
    ARVALID = 1'b1;
    RREADY  = (bp == 0);
    exp_q.push_back(oor(addr) ? 32'h0 : model_mem[addr[5:2]]);
    exp_r_q.push_back(oor(addr) ? 2'b10 : 2'b00);
    @(negedge clk);
    ARVALID = 1'b0;
    lat = 1;
    while (RVALID !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_rvalid_latency", 32'(lat), 32'd1);
    ed = exp_q.pop_front();
    er = exp_r_q.pop_front();
    chk("rd_rdata", RDATA, ed);
    chk("rd_rresp", 32'(RRESP), 32'(er));
    if (bp > 0) begin
      ARADDR  = 32'h4;
      ARVALID = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_rvalid_hold", 32'(RVALID), 32'd1);
        chk("bp_rdata_hold", RDATA, ed);
        chk("bp_rresp_hold", 32'(RRESP), 32'(er));
        chk("bp_arready_low", 32'(ARREADY), 32'd0);
      end
      RREADY  = 1'b1;
      ARVALID = 1'b0;
    end
    @(negedge clk);
    chk("rd_rvalid_drop", 32'(RVALID), 32'd0);
    chk("rd_arready_back", 32'(ARREADY), 32'd1);
    chk("rd_rdata_keep", RDATA, ed);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    logic [3:0]  rs;

    rst_N   = 1'b0;
    AWADDR  = '0;
    AWVALID = 1'b0;
    WDATA   = '0;
    WSTRB   = '0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    ARADDR  = '0;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    // Reset held for three cycles, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_rdata", RDATA, 32'h0);
    rst_N = 1'b1;
    @(negedge clk);
    chk("idle_awready", 32'(AWREADY), 32'd1);
    chk("idle_wready", 32'(WREADY), 32'd1);
    chk("idle_arready", 32'(ARREADY), 32'd1);
    chk("idle_bvalid", 32'(BVALID), 32'd0);
    chk("idle_rvalid", 32'(RVALID), 32'd0);
    chk("idle_rdata", RDATA, 32'h0);
    chk("idle_bresp", 32'(BRESP), 32'd0);
    chk("idle_rresp", 32'(RRESP), 32'd0);

    // Aligned write and read-back.
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(32'h04, 0);

    // W three cycles ahead of AW, partial strobe over a known word.
    do_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0);
    do_write(32'h08, 32'h11223344, 4'h5, 3, 0);
    do_read(32'h08, 0);

    // Response backpressure on both channels.
    do_write(32'h0C, 32'h0F0E0D0C, 4'hF, 0, 5);
    do_read(32'h0C, 5);

    // Out of range: 0x40 aliases word 0 by index, which must stay untouched.
    do_write(32'h00, 32'h01020304, 4'hF, 0, 0);
    do_write(32'h3C, 32'h0BADCAFE, 4'hF, 0, 0);
    do_write(32'h40, 32'h12345678, 4'hF, 0, 0);
    do_read(32'h40, 0);
    do_read(32'h3C, 0);
    do_read(32'h00, 0);

    // Zero strobe: OKAY response, no change.
    do_write(32'h04, 32'hFFFFFFFF, 4'h0, 0, 0);
    do_read(32'h04, 0);

    // Random traffic, including occasional out-of-range addresses.
    for (int n = 0; n < 6; n++) begin
      ra = 32'($urandom_range(0, 16)) << 2;
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      do_write(ra, rd, rs, int'($urandom_range(0, 2)), 0);
      do_read(32'($urandom_range(0, 16)) << 2, 0);
      do_read(ra, 0);
    end

    // Collision: AR handshake on the same edge as the write commit to 0x0C.
    @(negedge clk);
    AWADDR  = 32'h0C;
    WDATA   = 32'h55;
    WSTRB   = 4'hF;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    BREADY  = 1'b1;
    RREADY  = 1'b1;
    exp_b_q.push_back(2'b00);
    @(negedge clk);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    ARADDR  = 32'h0C;
    ARVALID = 1'b1;
    exp_q.push_back(model_mem[3]);
    exp_r_q.push_back(2'b00);
    model_mem[3] = 32'h55;
    @(negedge clk);
    ARVALID = 1'b0;
    chk("coll_rvalid", 32'(RVALID), 32'd1);
    chk("coll_rdata_old", RDATA, exp_q.pop_front());
    chk("coll_rresp", 32'(RRESP), 32'(exp_r_q.pop_front()));
    chk("coll_bvalid", 32'(BVALID), 32'd1);
    chk("coll_bresp", 32'(BRESP), 32'(exp_b_q.pop_front()));
    @(negedge clk);
    chk("coll_bvalid_drop", 32'(BVALID), 32'd0);
    chk("coll_rvalid_drop", 32'(RVALID), 32'd0);
    do_read(32'h0C, 0);

    // Mid-transaction reset: AW captured, W still pending.
    @(negedge clk);
    AWADDR  = 32'h10;
    AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    chk("mid_awready_low", 32'(AWREADY), 32'd0);
    chk("mid_wready_high", 32'(WREADY), 32'd1);
    #2;
    rst_N = 1'b0;
    #1;
    chk("arst_awready", 32'(AWREADY), 32'd0);
    chk("arst_wready", 32'(WREADY), 32'd0);
    chk("arst_arready", 32'(ARREADY), 32'd0);
    chk("arst_bvalid", 32'(BVALID), 32'd0);
    chk("arst_rvalid", 32'(RVALID), 32'd0);
    chk("arst_rdata", RDATA, 32'h0);
    chk("arst_bresp", 32'(BRESP), 32'd0);
    chk("arst_rresp", 32'(RRESP), 32'd0);
    @(negedge clk);
    rst_N = 1'b1;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    exp_q.delete();
    exp_r_q.delete();
    exp_b_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_bvalid", 32'(BVALID), 32'd0);
    end
    do_read(32'h10, 0);
    do_read(32'h04, 0);
    do_read(32'h0C, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
